ldm_stm_addr_gen: RTL and testbench
===================================

# ldm_stm_addr_gen

Multi-register transfer sequencer for the ARM core's load/store stage. It accepts a 16-bit LDM/STM register list and emits one register index per cycle, lowest index first. For each transfer it also emits the matching memory address for the selected addressing mode, and it provides the base-register write-back value. It sits between the instruction decoder (register list, base, mode) and the register file / data-memory port.

## Interface
Parameters:
- none; the 4-byte-word ARM register list is fixed at 16 entries.

Ports (one clock; reset is asynchronous and active-high):
- clk_in  input  1  rising-edge clock
- reset_in  input  1  asynchronous, active-high reset
- ldm_stm_start_in  input  1  one-cycle start pulse for a new LDM/STM
- data_in  input  16  register list; bit i set means Ri is transferred
- base_addr_in  input  32  base register value (Rn)
- offset_in  input  32  byte stride per transfer (normally 4)
- func_in  input  2  addressing mode: 00 IA, 01 IB, 10 DA, 11 DB
- swp_ctrl_S3_in  input  1  SWP stage-3 override
- reg_addr_out  output  4  register index of the current transfer
- ldm_stm_en_out  output  1  high while a transfer is pending
- addr_to_mem_out  output  32  data-memory address of the current transfer
- data_to_reg_update_out  output  32  base write-back value

## Operation
Start and register sequencing:
- Idle: no registers are pending. A start pulse sampled at a rising edge latches:
  - the pending list (data_in);
  - the base, stride and mode;
  - n = popcount(data_in), 5 bits.
- A start pulse is ignored while a sequence is busy (pending list nonzero).
- reg_addr_out = index of the lowest set bit of the pending list (priority encoder). It is 0 when the list is empty.
- ldm_stm_en_out = OR of the pending list.
- Each rising edge with ldm_stm_en_out high clears the lowest pending bit.

Address generation (mod 2^32 arithmetic; the stride may be any 32-bit value):
- Start address S:
  - IA: base
  - IB: base + stride
  - DA: base − (n−1)·stride
  - DB: base − n·stride
- The k-th transfer (k from 0, lowest register first) uses address S + k·stride. A running address register adds the stride on each advance.
- Write-back value: base + n·stride for IA/IB; base − n·stride for DA/DB. It is latched at the start edge and held until the next accepted start.
- Idle (en low): addr_to_mem_out = base_addr_in + offset_in, combinational, for single transfers.
- swp_ctrl_S3_in high: addr_to_mem_out = base_addr_in. This has priority over all other address sources.

Edge cases:
- Empty list (n = 0): the start is accepted, en never asserts, and write-back equals base.
- A full list (0xFFFF) gives 16 transfers.

## Timing
- Reset (asynchronous):
  - pending list = 0, running address = 0, write-back register = 0;
  - outputs: reg_addr_out 0, ldm_stm_en_out 0, data_to_reg_update_out 0;
  - addr_to_mem_out follows the idle rule.
- A reset asserted mid-sequence aborts it immediately.
- Start sampled at edge T:
  - en, reg_addr_out and address are valid after edge T;
  - the first transfer occupies cycle T..T+1;
  - en stays high for exactly n cycles and falls after edge T+n.
- Data_to_reg_update_out is valid from edge T.
- A start pulse coinciding with the final-transfer edge is ignored; restart one cycle after en falls.
- No input is sampled outside the start edge, except swp_ctrl_S3_in, base_addr_in and offset_in, which are combinational for the idle/SWP address.

## Structure
- Shared package: the mode encodings (IA/IB/DA/DB), WORD_BYTES = 4, and the register-list width of 16.
- One natural sub-module: mem_addr_calc, holding the start-address, running-address and write-back arithmetic. The top level holds the pending-list register, the priority encoder and the popcount.

## Test plan
- Start with list 0x6721, base 10, stride 5, IA. Required: reg_addr 0, 5, 8, 9, 10, 13, 14 on consecutive cycles; addr 10, 15, 20, 25, 30, 35, 40; en high for 7 cycles; write-back 45.
- Same list with base 100, stride 4, DB. Required: addr 72, 76, …, 96; write-back 72.
- IB with list 0x0003, base 0, stride 4. Required: addr 4, 8; write-back 8. DA with the same list: addr −4, 0; write-back −8.
- List 0x0000 started. Required: en stays low and write-back equals base. List 0xFFFF: 16 cycles, reg 0..15.
- Assert reset during the 3rd transfer. Required: en and reg_addr are 0 immediately. A start pulse during a busy sequence is ignored and the sequence continues unchanged.
- Idle with base 0x20, offset 8. Required: addr 0x28. Raise swp_ctrl_S3_in: addr 0x20.

Source files
------------

// File: rtl/ldm_stm_addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// ldm_stm_addr_gen_pkg
// Shared definitions for the LDM/STM transfer sequencer. This covers the
// addressing-mode encodings, the register-list geometry, and two small
// bit-scan helpers: population count and lowest-set-bit index.
// ---------------------------------------------------------------------------
package ldm_stm_addr_gen_pkg;

  localparam int REG_LIST_W = 16;
  localparam int REG_IDX_W  = 4;
  localparam int CNT_W      = 5;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    MODE_IA = 2'b00,
    MODE_IB = 2'b01,
    MODE_DA = 2'b10,
    MODE_DB = 2'b11
  } ldm_mode_e;

  function automatic logic [CNT_W-1:0] popcount_list(input logic [REG_LIST_W-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < REG_LIST_W; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // Scans from the top down so that the lowest set bit wins. An empty list
  // yields index 0.
  function automatic logic [REG_IDX_W-1:0] lowest_set_idx(input logic [REG_LIST_W-1:0] v);
    logic [REG_IDX_W-1:0] idx;
    idx = '0;
    for (int i = REG_LIST_W - 1; i >= 0; i--) begin
      if (v[i]) idx = REG_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ldm_stm_addr_gen_mem_addr_calc.sv
// ---------------------------------------------------------------------------
// ldm_stm_addr_gen_mem_addr_calc
// Address arithmetic for one LDM/STM sequence. All arithmetic is mod 2^32.
//   clk_in, reset_in   : clock and asynchronous active-high reset
//   load_in            : accepted start; computes start address and write-back
//   advance_in         : a transfer completes this edge; step the running address
//   base_in, stride_in : Rn and byte stride, sampled on load_in
//   mode_in            : IA/IB/DA/DB
//   count_in           : number of registers in the list
//   run_addr_out       : address of the current transfer
//   wb_out             : base write-back value, held until the next load
// ---------------------------------------------------------------------------
module ldm_stm_addr_gen_mem_addr_calc
  import ldm_stm_addr_gen_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  load_in,
  input  logic                  advance_in,
  input  logic [31:0]           base_in,
  input  logic [31:0]           stride_in,
  input  ldm_mode_e             mode_in,
  input  logic [CNT_W-1:0]      count_in,
  output logic [31:0]           run_addr_out,
  output logic [31:0]           wb_out
);

  logic [31:0] run_addr_q, run_addr_d;
  logic [31:0] stride_q, stride_d;
  logic [31:0] wb_q, wb_d;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] wb_calc;

  // span = n * stride, truncated to 32 bits.
  assign span = stride_in * {{(32-CNT_W){1'b0}}, count_in};

  always_comb begin
    start_addr = base_in;
    wb_calc    = base_in + span;
    unique case (mode_in)
      MODE_IA: start_addr = base_in;
      MODE_IB: start_addr = base_in + stride_in;
      // DA is written as base - n*stride + stride, the same as base - (n-1)*stride.
      MODE_DA: start_addr = base_in - span + stride_in;
      MODE_DB: start_addr = base_in - span;
      default: start_addr = base_in;
    endcase
    if (mode_in == MODE_DA || mode_in == MODE_DB) wb_calc = base_in - span;
  end

  always_comb begin
    run_addr_d = run_addr_q;
    stride_d   = stride_q;
    wb_d       = wb_q;
    if (load_in) begin
      run_addr_d = start_addr;
      stride_d   = stride_in;
      wb_d       = wb_calc;
    end else if (advance_in) begin
      run_addr_d = run_addr_q + stride_q;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      run_addr_q <= '0;
      stride_q   <= '0;
      wb_q       <= '0;
    end else begin
      run_addr_q <= run_addr_d;
      stride_q   <= stride_d;
      wb_q       <= wb_d;
    end
  end

  assign run_addr_out = run_addr_q;
  assign wb_out       = wb_q;

endmodule

// File: rtl/ldm_stm_addr_gen.sv
// ---------------------------------------------------------------------------
// ldm_stm_addr_gen
// LDM/STM multi-register transfer sequencer. It emits one register index per
// cycle, lowest first, together with the matching data-memory address. It
// also provides the base write-back value.
//   clk_in, reset_in        : clock and asynchronous active-high reset
//   ldm_stm_start_in        : start pulse; ignored while a sequence is pending
//   data_in                 : 16-bit register list
//   base_addr_in            : Rn
//   offset_in               : byte stride per transfer
//   func_in                 : 00 IA, 01 IB, 10 DA, 11 DB
//   swp_ctrl_S3_in          : forces addr_to_mem_out to base_addr_in
//   reg_addr_out            : register index of the current transfer
//   ldm_stm_en_out          : high while any register is pending
//   addr_to_mem_out         : memory address of the current transfer
//   data_to_reg_update_out  : base write-back value
// ---------------------------------------------------------------------------
module ldm_stm_addr_gen
  import ldm_stm_addr_gen_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  ldm_stm_start_in,
  input  logic [REG_LIST_W-1:0] data_in,
  input  logic [31:0]           base_addr_in,
  input  logic [31:0]           offset_in,
  input  logic [1:0]            func_in,
  input  logic                  swp_ctrl_S3_in,
  output logic [REG_IDX_W-1:0]  reg_addr_out,
  output logic                  ldm_stm_en_out,
  output logic [31:0]           addr_to_mem_out,
  output logic [31:0]           data_to_reg_update_out
);

  logic [REG_LIST_W-1:0] pending_q, pending_d;
  logic                  busy;
  logic                  accept;
  logic [31:0]           run_addr;

  assign busy   = |pending_q;
  assign accept = ldm_stm_start_in && !busy;

  // x & (x-1) clears the lowest set bit, which is the register just transferred.
  always_comb begin
    pending_d = pending_q;
    if (accept)    pending_d = data_in;
    else if (busy) pending_d = pending_q & (pending_q - 1'b1);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  ldm_stm_addr_gen_mem_addr_calc u_mem_addr_calc (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .load_in      (accept),
    .advance_in   (busy),
    .base_in      (base_addr_in),
    .stride_in    (offset_in),
    .mode_in      (ldm_mode_e'(func_in)),
    .count_in     (popcount_list(data_in)),
    .run_addr_out (run_addr),
    .wb_out       (data_to_reg_update_out)
  );

  assign reg_addr_out   = lowest_set_idx(pending_q);
  assign ldm_stm_en_out = busy;

  // SWP override first, then the sequenced address, then the single-transfer default.
  always_comb begin
    addr_to_mem_out = base_addr_in + offset_in;
    if (swp_ctrl_S3_in)      addr_to_mem_out = base_addr_in;
    else if (busy)           addr_to_mem_out = run_addr;
  end

endmodule

// File: tb/tb_ldm_stm_addr_gen.sv
module tb_ldm_stm_addr_gen;
  import ldm_stm_addr_gen_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        ldm_stm_start_in = 1'b0;
  logic [15:0] data_in = '0;
  logic [31:0] base_addr_in = 32'h20;
  logic [31:0] offset_in = 32'd8;
  logic [1:0]  func_in = 2'b00;
  logic        swp_ctrl_S3_in = 1'b0;
  logic [3:0]  reg_addr_out;
  logic        ldm_stm_en_out;
  logic [31:0] addr_to_mem_out;
  logic [31:0] data_to_reg_update_out;

  typedef struct packed {
    logic [3:0]  ridx;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   en_cycles = 0;

  ldm_stm_addr_gen dut (
    .clk_in                 (clk_in),
    .reset_in               (reset_in),
    .ldm_stm_start_in       (ldm_stm_start_in),
    .data_in                (data_in),
    .base_addr_in           (base_addr_in),
    .offset_in              (offset_in),
    .func_in                (func_in),
    .swp_ctrl_S3_in         (swp_ctrl_S3_in),
    .reg_addr_out           (reg_addr_out),
    .ldm_stm_en_out         (ldm_stm_en_out),
    .addr_to_mem_out        (addr_to_mem_out),
    .data_to_reg_update_out (data_to_reg_update_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle in which the DUT presents a transfer.
  initial begin
    forever begin
      @(negedge clk_in);
      if (ldm_stm_en_out) begin
        en_cycles++;
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", {28'd0, reg_addr_out}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("reg_addr", {28'd0, reg_addr_out}, {28'd0, e.ridx});
          check("mem_addr", addr_to_mem_out, e.addr);
        end
      end
    end
  end

  // Push the expected transfers. Start addresses are given by hand per case.
  task automatic push_seq(input logic [15:0] list, input logic [31:0] start_addr,
                          input logic [31:0] stride);
    logic [31:0] a;
    a = start_addr;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        exp_q.push_back('{ridx: 4'(i), addr: a});
        a = a + stride;
      end
    end
  endtask

  task automatic pulse_start(input logic [15:0] list, input logic [31:0] base,
                             input logic [31:0] stride, input logic [1:0] mode);
    @(posedge clk_in); #2;
    data_in = list; base_addr_in = base; offset_in = stride; func_in = mode;
    ldm_stm_start_in = 1'b1;
    @(posedge clk_in); #2;
    ldm_stm_start_in = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (ldm_stm_en_out && cyc < 64) begin
      @(posedge clk_in); #2;
      cyc++;
    end
    if (cyc >= 64) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_seq(input string name, input logic [15:0] list, input logic [31:0] base,
                         input logic [31:0] stride, input logic [1:0] mode,
                         input logic [31:0] start_addr, input int n, input logic [31:0] wb);
    push_seq(list, start_addr, stride);
    en_cycles = 0;
    pulse_start(list, base, stride, mode);
    check({name, "_wb"}, data_to_reg_update_out, wb);
    wait_idle();
    check({name, "_en_cycles"}, 32'(en_cycles), 32'(n));
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_wb_hold"}, data_to_reg_update_out, wb);
  endtask

  initial begin
    // Reset state; the idle address follows base + offset.
    #3;
    check("rst_en", {31'd0, ldm_stm_en_out}, 32'd0);
    check("rst_reg", {28'd0, reg_addr_out}, 32'd0);
    check("rst_wb", data_to_reg_update_out, 32'd0);
    check("rst_idle_addr", addr_to_mem_out, 32'h28);
    #9 reset_in = 1'b0;

    // IA, list 0x6721, base 10, stride 5.
    run_seq("ia", 16'h6721, 32'd10, 32'd5, 2'b00, 32'd10, 7, 32'd45);

    // DB, same list, base 100, stride 4. A start issued mid-sequence is ignored.
    push_seq(16'h6721, 32'd72, 32'd4);
    en_cycles = 0;
    pulse_start(16'h6721, 32'd100, 32'd4, 2'b11);
    check("db_wb", data_to_reg_update_out, 32'd72);
    data_in = 16'hFFFF; base_addr_in = 32'd0; func_in = 2'b00;
    ldm_stm_start_in = 1'b1;
    @(posedge clk_in); #2;
    ldm_stm_start_in = 1'b0;
    wait_idle();
    check("db_en_cycles", 32'(en_cycles), 32'd7);
    check("db_drained", 32'(exp_q.size()), 32'd0);
    check("db_wb_hold", data_to_reg_update_out, 32'd72);

    // IB and DA with list 0x0003, base 0, stride 4.
    run_seq("ib", 16'h0003, 32'd0, 32'd4, 2'b01, 32'd4, 2, 32'd8);
    run_seq("da", 16'h0003, 32'd0, 32'd4, 2'b10, 32'hFFFF_FFFC, 2, 32'hFFFF_FFF8);

    // Empty list: accepted, no transfers, write-back equals base.
    run_seq("empty", 16'h0000, 32'h55, 32'd4, 2'b00, 32'd0, 0, 32'h55);

    // Full list: sixteen transfers.
    run_seq("full", 16'hFFFF, 32'h1000, 32'd4, 2'b00, 32'h1000, 16, 32'h1040);

    // Reset during the third transfer aborts immediately.
    push_seq(16'h6721, 32'd10, 32'd5);
    pulse_start(16'h6721, 32'd10, 32'd5, 2'b00);
    @(posedge clk_in); #2;
    @(posedge clk_in); #2;
    reset_in = 1'b1;
    #1;
    check("abort_en", {31'd0, ldm_stm_en_out}, 32'd0);
    check("abort_reg", {28'd0, reg_addr_out}, 32'd0);
    check("abort_wb", data_to_reg_update_out, 32'd0);
    check("abort_left", 32'(exp_q.size()), 32'd5);
    @(negedge clk_in); #1;
    reset_in = 1'b0;
    exp_q.delete();

    // Idle single-transfer address and SWP override.
    @(posedge clk_in); #2;
    base_addr_in = 32'h20; offset_in = 32'd8;
    #1 check("idle_addr", addr_to_mem_out, 32'h28);
    swp_ctrl_S3_in = 1'b1;
    #1 check("swp_addr", addr_to_mem_out, 32'h20);
    swp_ctrl_S3_in = 1'b0;

    repeat (3) @(posedge clk_in);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
